// File: rtl/keyboard_ctl.sv
// keyboard_ctl: PS/2 set-2 scan-code sequencer producing paddle, serve and pause controls.
module keyboard_ctl #(
    parameter int HOLD_TIMEOUT   = 100_000_000,
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_byte,
    input  logic       byte_valid,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       serve,
    output logic       pause,
    output logic       active
);
    localparam int HW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam int PW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TIMEOUT - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PREFIX_TIMEOUT - 1);
    // bit0 = extended prefix seen, bit1 = break prefix seen
    localparam logic [1:0] IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    held_q, held_d, hit;
    logic [1:0]    last_q, last_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [6:0]    out_q, out_d;
    logic          is_e0, is_f0, code, mk, plain, hold_exp, pre_exp;

    always_comb begin
        is_e0    = scan_byte == 8'hE0;
        is_f0    = scan_byte == 8'hF0;
        code     = byte_valid && !is_e0 && !is_f0;
        mk       = code && !state_q[1];
        plain    = !state_q[0];
        hold_exp = hold_cnt_q == HOLD_MAX;
        pre_exp  = state_q != IDLE && pre_cnt_q == PRE_MAX;
        state_d  = byte_valid ? (is_e0 ? {state_q[1], 1'b1} : is_f0 ? {1'b1, state_q[0]} : IDLE)
                 : (hold_exp || pre_exp) ? IDLE : state_q;
        hit      = {4{code}} & {plain && scan_byte == 8'h1D, plain && scan_byte == 8'h1B,
                                !plain && scan_byte == 8'h75, !plain && scan_byte == 8'h72};
        held_d   = (!byte_valid && hold_exp) ? 4'b0 : state_q[1] ? held_q & ~hit : held_q | hit;
        last_d   = {(mk && hit[3]) ? 1'b1 : (mk && hit[2]) ? 1'b0 : last_q[1],
                    (mk && hit[1]) ? 1'b1 : (mk && hit[0]) ? 1'b0 : last_q[0]};
        hold_cnt_d = byte_valid ? '0 : hold_exp ? hold_cnt_q : hold_cnt_q + 1'b1;
        pre_cnt_d  = (byte_valid || state_q == IDLE) ? '0 : pre_exp ? pre_cnt_q : pre_cnt_q + 1'b1;
        // last-pressed key wins when both directions of a player are held
        out_d = {held_d[3] & (~held_d[2] | last_d[1]),
                 held_d[2] & (~held_d[3] | ~last_d[1]),
                 held_d[1] & (~held_d[0] | last_d[0]),
                 held_d[0] & (~held_d[1] | ~last_d[0]),
                 mk && plain && scan_byte == 8'h29,
                 mk && plain && scan_byte == 8'h76,
                 |held_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            held_q     <= '0;
            last_q     <= '0;
            hold_cnt_q <= '0;
            pre_cnt_q  <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            out_q      <= out_d;
        end
    end

    assign {p1_up, p1_down, p2_up, p2_down, serve, pause, active} = out_q;
endmodule

// File: doc/keyboard_ctl.md
Name: keyboard_ctl

Overview:
- Byte-level PS/2 scan-code sequencer between the PS/2 receiver and the paddle input mux.
- Parses the set-2 prefix stream (E0 extended, F0 break) and maintains held-key state for two players: P1 W/S, P2 Up/Down arrows.
- Resolves up+down conflicts, emits serve and pause pulses, and clears stuck keys on link silence.

Parameters:
- HOLD_TIMEOUT, 100_000_000: cycles with no received byte after which all held keys are cleared (1 s at 100 MHz).
- PREFIX_TIMEOUT, 1_000_000: cycles a prefix state may persist before the FSM returns to IDLE (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- scan_byte  in  8  received PS/2 byte.
- byte_valid  in  1  one-cycle strobe; scan_byte is valid in that cycle.
- p1_up  out  1  player 1 up request, level.
- p1_down  out  1  player 1 down request, level.
- p2_up  out  1  player 2 up request, level.
- p2_down  out  1  player 2 down request, level.
- serve  out  1  one-cycle pulse on a Space make (29).
- pause  out  1  one-cycle pulse on an Esc make (76).
- active  out  1  high while any tracked key is held.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, all held bits 0, last_dir bits 0, counters 0, all outputs 0.
- FSM states: IDLE, EXT, BRK, EXT_BRK. All transitions occur only on byte_valid.
  - IDLE: E0->EXT; F0->BRK; other byte = plain make, stay IDLE.
  - EXT: F0->EXT_BRK; E0 stays EXT; other byte = extended make, ->IDLE.
  - BRK: F0 stays BRK; E0->EXT_BRK; other byte = plain break, ->IDLE.
  - EXT_BRK: E0/F0 stay; other byte = extended break, ->IDLE.
- Key map:
  - plain 1D = P1 up; plain 1B = P1 down.
  - extended 75 = P2 up; extended 72 = P2 down.
  - plain 29 = serve; plain 76 = pause.
- Make of a direction key: set its held bit and set last_dir for that player (UP=1 or DOWN=0).
- Break of a direction key: clear its held bit; last_dir unchanged.
- Typematic repeat makes of an already-held key: held bit unchanged, last_dir rewritten to that key. This is harmless because repeats come only from the newest key.
- Unmapped codes: no effect on key state; FSM still returns to IDLE.
- Bytes FA, AA, EE, FE in IDLE are ignored and do not change state.
- Output resolution, per player: up = held_up & (~held_down | last_dir); down = held_down & (~held_up | ~last_dir). Up and down are never both 1 (last-pressed wins).
- Latency: direction outputs, serve, pause and active are registered and update exactly one cycle after the byte_valid cycle carrying the final byte of the code.
- serve and pause are high for exactly one cycle per make. Typematic repeats of 29/76 do pulse again; no break is required in between.
- active = OR of the four held bits, registered.
- Hold watchdog:
  - Counter resets to 0 on every byte_valid and otherwise increments, saturating.
  - When it reaches HOLD_TIMEOUT-1 with no byte_valid, all held bits are cleared next cycle and the FSM is forced to IDLE.
- Prefix watchdog:
  - Counter runs only while FSM is not IDLE and resets on byte_valid.
  - At PREFIX_TIMEOUT-1 the FSM returns to IDLE; key state is unchanged.
- Simultaneous byte_valid and timeout expiry: the byte wins (counters reset, the byte is processed normally).
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.
- Reset asserted mid-sequence (e.g. in EXT_BRK): immediate return to reset state; a trailing byte after reset release is parsed from IDLE.

Test Plan:
- Byte 1D -> p1_up=1 one cycle after the strobe. Then F0,1D -> p1_up=0. active follows 1->0.
- Bytes E0,75 -> p2_up=1; later E0,F0,75 -> p2_up=0. Bytes 1D/75 without E0 must not drive the other player (plain 75 has no effect).
- 1D then 1B -> p1_down=1, p1_up=0. Then F0,1B -> p1_up=1 again (up still held).
- 29 -> serve high exactly 1 cycle. 76,76 -> two pause pulses. F0,29 -> no serve pulse.
- HOLD_TIMEOUT=16: byte 1D, then no strobes for 16 cycles -> p1_up=0 and active=0.
- PREFIX_TIMEOUT=8: E0, silence for 8 cycles, then 75 -> treated as plain 75 (no p2_up).
- Reset asserted while in EXT_BRK -> all outputs 0 immediately.
